// File: rtl/ddr4_cmd_sched.sv
// DDR4 per-bank command scheduler: tracks open rows and bank timing, turns CPU
// requests into ACT/PRE/RD/WR and interleaves PREA/REF with postponable refresh.
module ddr4_cmd_sched #(
  parameter int BG_W         = 2,
  parameter int BA_W         = 2,
  parameter int ROW_W        = 17,
  parameter int COL_W        = 10,
  parameter int TRCD         = 11,
  parameter int TRP          = 11,
  parameter int TRAS         = 28,
  parameter int CL           = 11,
  parameter int CWL          = 11,
  parameter int TBL          = 4,
  parameter int TWR          = 12,
  parameter int TRTP         = 6,
  parameter int TRRD_S       = 4,
  parameter int TRRD_L       = 5,
  parameter int TRFC         = 128,
  parameter int TREFI        = 6240,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                                clkin,
  input  logic                                crst,
  input  logic                                init_done,
  input  logic                                req_valid,
  input  logic                                req_wr,
  input  logic [BG_W+BA_W+ROW_W+COL_W-1:0]    req_addr,
  output logic                                req_ready,
  output logic                                cmd_valid,
  output logic [2:0]                          cmd,
  output logic [BG_W-1:0]                     cmd_bg,
  output logic [BA_W-1:0]                     cmd_ba,
  output logic [ROW_W-1:0]                    cmd_row,
  output logic [COL_W-1:0]                    cmd_col,
  output logic [3:0]                          ref_owed,
  output logic [2:0]                          curr_state
);

  localparam int ADDR_W = BG_W + BA_W + ROW_W + COL_W;
  localparam int BK_W   = BG_W + BA_W;
  localparam int NB     = 1 << BK_W;
  localparam int TW     = 16;
  localparam int RW     = 8;

  // Timers store "cycles until allowed" minus one: the decision cycle is one
  // cycle ahead of the bus, so a zero timer lands the command exactly tX later.
  localparam logic [TW-1:0] LD_TRCD = TW'(TRCD - 1);
  localparam logic [TW-1:0] LD_TRP  = TW'(TRP - 1);
  localparam logic [TW-1:0] LD_TRAS = TW'(TRAS - 1);
  localparam logic [TW-1:0] LD_TRFC = TW'(TRFC - 1);
  localparam logic [TW-1:0] LD_RD   = TW'(CL + TBL + TRTP - 1);
  localparam logic [TW-1:0] LD_WR   = TW'(CWL + TBL + TWR - 1);
  localparam logic [RW-1:0] LD_RRD  = RW'(TRRD_L - 1);
  localparam logic [RW-1:0] RRD_DIF = RW'(TRRD_L - TRRD_S);
  localparam logic [TW-1:0] REFI_MX = TW'(TREFI - 1);
  localparam logic [3:0]    OWE_FRC = 4'(MAX_POSTPONE);
  localparam logic [3:0]    OWE_MAX = 4'(MAX_POSTPONE + 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_SERVE   = 3'd1,
    ST_REF_PRE = 3'd2,
    ST_REF_CMD = 3'd3
  } state_t;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == TW'(0)) ? v : v - TW'(1);
  endfunction

  function automatic logic [TW-1:0] max_tw(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [NB-1:0]       open_r;
  logic [ROW_W-1:0]    row_r   [NB];
  logic [TW-1:0]       t_cmd_r [NB];
  logic [TW-1:0]       t_pre_r [NB];
  logic [RW-1:0]       rrd_r;
  logic [BG_W-1:0]     last_act_bg_r;
  logic [TW-1:0]       refi_r;
  logic [3:0]          ref_owed_r;
  logic                cmd_valid_r;
  logic [2:0]          cmd_r, cmd_nxt_s;
  logic [BG_W-1:0]     cmd_bg_r, bg_nxt_s;
  logic [BA_W-1:0]     cmd_ba_r, ba_nxt_s;
  logic [ROW_W-1:0]    cmd_row_r, row_nxt_s;
  logic [COL_W-1:0]    cmd_col_r, col_nxt_s;
  logic                req_ready_s;
  logic                all_cmd_zero_s, all_pre_zero_s;

  logic [BG_W-1:0]  bg_s;
  logic [BA_W-1:0]  ba_s;
  logic [ROW_W-1:0] row_s;
  logic [COL_W-1:0] col_s;
  logic [BK_W-1:0]  b_s;
  logic             row_hit_s, rrd_ok_s, wrap_s, ref_issue_s;

  assign bg_s   = req_addr[ADDR_W-1 -: BG_W];
  assign ba_s   = req_addr[ADDR_W-BG_W-1 -: BA_W];
  assign row_s  = req_addr[COL_W +: ROW_W];
  assign col_s  = req_addr[COL_W-1:0];
  assign b_s    = {bg_s, ba_s};
  assign row_hit_s   = (row_r[b_s] == row_s);
  assign rrd_ok_s    = (bg_s == last_act_bg_r) ? (rrd_r == RW'(0)) : (rrd_r <= RRD_DIF);
  assign wrap_s      = (state_r != ST_INIT) && (refi_r == REFI_MX);
  assign ref_issue_s = (cmd_nxt_s == CMD_REF);

  // Reduce per-bank timers to the all-clear flags used by the refresh states.
  always_comb begin
    all_cmd_zero_s = 1'b1;
    all_pre_zero_s = 1'b1;
    for (int i = 0; i < NB; i++) begin
      all_cmd_zero_s = all_cmd_zero_s & (t_cmd_r[i] == TW'(0));
      all_pre_zero_s = all_pre_zero_s & (t_pre_r[i] == TW'(0));
    end
  end

  // Next-state and next-command decision; the chosen command is registered onto the bus.
  always_comb begin
    state_nxt_s = state_r;
    cmd_nxt_s   = CMD_NOP;
    bg_nxt_s    = {BG_W{1'b0}};
    ba_nxt_s    = {BA_W{1'b0}};
    row_nxt_s   = {ROW_W{1'b0}};
    col_nxt_s   = {COL_W{1'b0}};
    req_ready_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (init_done) state_nxt_s = ST_SERVE;
        else           state_nxt_s = ST_INIT;
      end
      ST_SERVE: begin
        if (ref_owed_r >= OWE_FRC) begin
          state_nxt_s = ST_REF_PRE;
        end else if ((ref_owed_r != 4'd0) && !req_valid) begin
          state_nxt_s = ST_REF_PRE;
        end else if (req_valid && open_r[b_s] && row_hit_s && (t_cmd_r[b_s] == TW'(0))) begin
          cmd_nxt_s   = req_wr ? CMD_WR : CMD_RD;
          bg_nxt_s    = bg_s;
          ba_nxt_s    = ba_s;
          col_nxt_s   = col_s;
          req_ready_s = 1'b1;
        end else if (req_valid && open_r[b_s] && !row_hit_s &&
                     (t_pre_r[b_s] == TW'(0)) && (t_cmd_r[b_s] == TW'(0))) begin
          cmd_nxt_s = CMD_PRE;
          bg_nxt_s  = bg_s;
          ba_nxt_s  = ba_s;
        end else if (req_valid && !open_r[b_s] && (t_cmd_r[b_s] == TW'(0)) && rrd_ok_s) begin
          cmd_nxt_s = CMD_ACT;
          bg_nxt_s  = bg_s;
          ba_nxt_s  = ba_s;
          row_nxt_s = row_s;
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      ST_REF_PRE: begin
        if (open_r == {NB{1'b0}}) begin
          if (all_cmd_zero_s) state_nxt_s = ST_REF_CMD;
          else                state_nxt_s = ST_REF_PRE;
        end else if (all_pre_zero_s) begin
          cmd_nxt_s   = CMD_PREA;
          state_nxt_s = ST_REF_CMD;
        end else begin
          state_nxt_s = ST_REF_PRE;
        end
      end
      ST_REF_CMD: begin
        if (all_cmd_zero_s) begin
          cmd_nxt_s   = CMD_REF;
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_REF_CMD;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // State and registered command bus.
  always_ff @(posedge clkin or posedge crst) begin
    if (crst) begin
      state_r     <= ST_INIT;
      cmd_valid_r <= 1'b0;
      cmd_r       <= CMD_NOP;
      cmd_bg_r    <= {BG_W{1'b0}};
      cmd_ba_r    <= {BA_W{1'b0}};
      cmd_row_r   <= {ROW_W{1'b0}};
      cmd_col_r   <= {COL_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cmd_valid_r <= (cmd_nxt_s != CMD_NOP);
      cmd_r       <= cmd_nxt_s;
      cmd_bg_r    <= bg_nxt_s;
      cmd_ba_r    <= ba_nxt_s;
      cmd_row_r   <= row_nxt_s;
      cmd_col_r   <= col_nxt_s;
    end
  end

  // Per-bank open/row tracking and timers; a load overrides the decrement.
  always_ff @(posedge clkin or posedge crst) begin
    if (crst) begin
      open_r <= {NB{1'b0}};
      for (int i = 0; i < NB; i++) begin
        row_r[i]   <= {ROW_W{1'b0}};
        t_cmd_r[i] <= TW'(0);
        t_pre_r[i] <= TW'(0);
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        t_cmd_r[i] <= dec_sat(t_cmd_r[i]);
        t_pre_r[i] <= dec_sat(t_pre_r[i]);
        if (cmd_nxt_s == CMD_PREA) begin
          open_r[i]  <= 1'b0;
          t_cmd_r[i] <= LD_TRP;
        end else if (cmd_nxt_s == CMD_REF) begin
          t_cmd_r[i] <= LD_TRFC;
        end else if (b_s == BK_W'(i)) begin
          case (cmd_nxt_s)
            CMD_ACT: begin
              open_r[i]  <= 1'b1;
              row_r[i]   <= row_s;
              t_cmd_r[i] <= LD_TRCD;
              t_pre_r[i] <= LD_TRAS;
            end
            CMD_RD:  t_pre_r[i] <= max_tw(dec_sat(t_pre_r[i]), LD_RD);
            CMD_WR:  t_pre_r[i] <= max_tw(dec_sat(t_pre_r[i]), LD_WR);
            CMD_PRE: begin
              open_r[i]  <= 1'b0;
              t_cmd_r[i] <= LD_TRP;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Global ACT-to-ACT spacing.
  always_ff @(posedge clkin or posedge crst) begin
    if (crst) begin
      rrd_r         <= RW'(0);
      last_act_bg_r <= {BG_W{1'b0}};
    end else if (cmd_nxt_s == CMD_ACT) begin
      rrd_r         <= LD_RRD;
      last_act_bg_r <= bg_s;
    end else begin
      rrd_r <= (rrd_r == RW'(0)) ? rrd_r : rrd_r - RW'(1);
    end
  end

  // Refresh interval counter and owed-refresh bookkeeping.
  always_ff @(posedge clkin or posedge crst) begin
    if (crst) begin
      refi_r     <= TW'(0);
      ref_owed_r <= 4'd0;
    end else begin
      if (state_r == ST_INIT) refi_r <= TW'(0);
      else if (wrap_s)        refi_r <= TW'(0);
      else                    refi_r <= refi_r + TW'(1);
      if (wrap_s && !ref_issue_s && (ref_owed_r != OWE_MAX)) ref_owed_r <= ref_owed_r + 4'd1;
      else if (ref_issue_s && !wrap_s && (ref_owed_r != 4'd0)) ref_owed_r <= ref_owed_r - 4'd1;
      else ref_owed_r <= ref_owed_r;
    end
  end

  assign req_ready  = req_ready_s;
  assign cmd_valid  = cmd_valid_r;
  assign cmd        = cmd_r;
  assign cmd_bg     = cmd_bg_r;
  assign cmd_ba     = cmd_ba_r;
  assign cmd_row    = cmd_row_r;
  assign cmd_col    = cmd_col_r;
  assign ref_owed   = ref_owed_r;
  assign curr_state = state_r;

endmodule

// File: tb/tb_ddr4_cmd_sched.sv
// Scoreboard bench for ddr4_cmd_sched: directed requests push expected commands
// (with cycle gap to the previous command); a monitor pops and compares them.
module tb_ddr4_cmd_sched;
  localparam int AW = 31;

  logic clkin = 1'b0;
  logic crst, init_done, req_valid, req_wr;
  logic [AW-1:0] req_addr;
  logic req_ready, cmd_valid;
  logic [2:0] cmd, curr_state;
  logic [1:0] cmd_bg, cmd_ba;
  logic [16:0] cmd_row;
  logic [9:0] cmd_col;
  logic [3:0] ref_owed;

  ddr4_cmd_sched #(.TREFI(100), .MAX_POSTPONE(2)) dut (
    .clkin(clkin), .crst(crst), .init_done(init_done), .req_valid(req_valid),
    .req_wr(req_wr), .req_addr(req_addr), .req_ready(req_ready), .cmd_valid(cmd_valid),
    .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .ref_owed(ref_owed), .curr_state(curr_state));

  always #5 clkin = ~clkin;

  typedef struct {
    logic [2:0]  c;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_cyc = 0, ready_cnt = 0, cmd_cnt = 0;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  function automatic logic [AW-1:0] mk_addr(input int bg, input int ba, input int row, input int col);
    return {2'(bg), 2'(ba), 17'(row), 10'(col)};
  endfunction

  task automatic expect_cmd(input logic [2:0] c, input int bg, input int ba, input int row,
                            input int col, input int gap);
    exp_t e;
    e.c = c; e.bg = 2'(bg); e.ba = 2'(ba); e.row = 17'(row); e.col = 10'(col); e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: pop and compare every command that appears on the bus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clkin);
      if (req_ready) ready_cnt++;
      if (!crst && cmd_valid) begin
        cmd_cnt++;
        if (exp_q.size() == 0) begin
          timeout($sformatf("unexpected_cmd cmd=%0d bg=%0d ba=%0d", cmd, cmd_bg, cmd_ba));
        end else begin
          e = exp_q.pop_front();
          check("cmd_code", 64'(cmd), 64'(e.c));
          check("cmd_fields", 64'({cmd_bg, cmd_ba, cmd_row, cmd_col}),
                64'({e.bg, e.ba, e.row, e.col}));
          if (e.gap != 0) check("cmd_gap", 64'(cyc - last_cyc), 64'(e.gap));
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic do_reset();
    crst = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    repeat (3) @(posedge clkin);
    #1 crst = 1'b0;
  endtask

  // Present a request until accepted, then expect RD/WR with the given gap.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input int gap);
    bit ok = 1'b0;
    req_valid = 1'b1; req_wr = wr; req_addr = a;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clkin);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      timeout("req_accept");
      req_valid = 1'b0;
    end else begin
      @(posedge clkin);
      #1;
      expect_cmd(wr ? 3'd3 : 3'd2, int'(a[30:29]), int'(a[28:27]), 0, int'(a[9:0]), gap);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_cmd(input logic [2:0] c);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clkin);
      if (cmd_valid && cmd == c) ok = 1'b1;
    end
    if (!ok) timeout($sformatf("wait_cmd_%0d", c));
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clkin);
    if (exp_q.size() > 0) timeout("drain");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, c0, g, n;
    // Test 1: reset state, then first read opens row 5 and reads col 3.
    do_reset();
    check("reset_state", 64'({cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
                              req_ready, ref_owed, curr_state}), 64'd0);
    init_done = 1'b1;
    r0 = ready_cnt;
    expect_cmd(3'd1, 0, 0, 5, 0, 0);
    issue(1'b0, mk_addr(0, 0, 5, 3), 11);
    check("t1_ready_pulses", 64'(ready_cnt - r0), 64'd1);
    // Test 2: row hit right after, read the next cycle.
    issue(1'b0, mk_addr(0, 0, 5, 7), 1);
    drain();

    // Test 3: row miss forces PRE after tRAS/tRTP, then ACT 11 later, then WR.
    do_reset();
    init_done = 1'b1;
    expect_cmd(3'd1, 0, 0, 5, 0, 0);
    issue(1'b0, mk_addr(0, 0, 5, 0), 11);
    expect_cmd(3'd4, 0, 0, 0, 0, 21);
    expect_cmd(3'd1, 0, 0, 9, 0, 11);
    issue(1'b1, mk_addr(0, 0, 9, 1), 11);
    drain();

    // Test 4: ACT spacing, same group 5 cycles, different group 4 cycles.
    do_reset();
    init_done = 1'b1;
    expect_cmd(3'd1, 0, 0, 1, 0, 0);
    expect_cmd(3'd1, 0, 1, 2, 0, 5);
    expect_cmd(3'd1, 1, 0, 3, 0, 4);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = mk_addr(0, 0, 1, 0);
    wait_cmd(3'd1);
    req_addr = mk_addr(0, 1, 2, 0);
    wait_cmd(3'd1);
    req_addr = mk_addr(1, 0, 3, 0);
    wait_cmd(3'd1);
    req_valid = 1'b0;
    drain();

    // Test 5: row-hit traffic until two refreshes are owed, then forced refresh.
    do_reset();
    init_done = 1'b1;
    expect_cmd(3'd1, 0, 0, 5, 0, 0);
    g = 11;
    n = 0;
    while (ref_owed != 4'd2 && n < 400) begin
      issue(1'b0, mk_addr(0, 0, 5, n % 1024), g);
      g = 1;
      n++;
    end
    check("t5_owed_before", 64'(ref_owed), 64'd2);
    expect_cmd(3'd5, 0, 0, 0, 0, 21);
    expect_cmd(3'd6, 0, 0, 0, 0, 11);
    wait_cmd(3'd6);
    check("t5_owed_after", 64'(ref_owed), 64'd1);
    c0 = cmd_cnt;
    repeat (127) @(negedge clkin);
    check("t5_trfc_quiet", 64'(cmd_cnt - c0), 64'd0);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Test 6: reset during tRCD wait, then idle until init_done.
    do_reset();
    init_done = 1'b1;
    expect_cmd(3'd1, 0, 0, 5, 0, 0);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = mk_addr(0, 0, 5, 4);
    wait_cmd(3'd1);
    repeat (3) @(posedge clkin);
    #2 crst = 1'b1;
    #1 check("t6_reset_outputs", 64'({cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col,
                                      req_ready, ref_owed, curr_state}), 64'd0);
    init_done = 1'b0;
    @(posedge clkin);
    #1 crst = 1'b0;
    c0 = cmd_cnt;
    repeat (20) @(negedge clkin);
    check("t6_idle_cmds", 64'(cmd_cnt - c0), 64'd0);
    check("t6_state_init", 64'(curr_state), 64'd0);
    init_done = 1'b1;
    expect_cmd(3'd1, 0, 0, 5, 0, 0);
    issue(1'b0, mk_addr(0, 0, 5, 4), 11);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
